reg_bank_param: RTL and testbench

Parametrised register bank for the datapath: `NUM_REGS = 2**ADDR_W` registers, each `DATA_W` bits wide. It has two registered read ports, one synchronous write port and a per-register busy scoreboard. Optional features are write-to-read bypass and a hard-wired zero register. It sits between the decode stage, which supplies read and reservation requests, and the ALU writeback, which supplies writes. It gives the controller operands plus hazard flags in one cycle.

---
 rtl/reg_bank_param.sv | 120 ++++++++++++
 tb/tb_reg_bank_param.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/reg_bank_param.sv
// Parametrised register bank: two registered read ports, one write port,
// per-register busy scoreboard, optional write-to-read bypass and zero register.
module reg_bank_param #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 3,
   parameter int INIT_STEP = 10,
   parameter int ZERO_R0   = 1,
   parameter int BYPASS    = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_en,
   input  logic [ADDR_W-1:0]      ra1,
   input  logic [ADDR_W-1:0]      ra2,
   output logic [DATA_W-1:0]      rd1_data,
   output logic [DATA_W-1:0]      rd2_data,
   output logic                   busy1,
   output logic                   busy2,
   output logic                   rd_valid,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      wa,
   input  logic [DATA_W-1:0]      wd,
   input  logic                   rsv_en,
   input  logic [ADDR_W-1:0]      rsv_addr,
   output logic [2**ADDR_W-1:0]   busy_vec
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0]   r_mem [NUM_REGS];
   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_next;
   logic [DATA_W-1:0]   r_rd1;
   logic [DATA_W-1:0]   r_rd2;
   logic                r_busy1;
   logic                r_busy2;
   logic                r_valid;
   logic                w_wr_eff;
   logic                w_rsv_eff;
   logic [DATA_W-1:0]   w_rd1_next;
   logic [DATA_W-1:0]   w_rd2_next;

   // Writes and reservations aimed at a hard-wired r0 are dropped here once,
   // so the storage and scoreboard never need to special-case it.
   always_comb begin
      w_wr_eff  = we;
      w_rsv_eff = rsv_en;
      if (ZERO_R0 != 0) begin
         if (wa == '0)       w_wr_eff  = 1'b0;
         if (rsv_addr == '0) w_rsv_eff = 1'b0;
      end
   end

   function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = r_mem[a];
      if ((BYPASS != 0) && w_wr_eff && (wa == a)) v = wd;
      if ((ZERO_R0 != 0) && (a == '0))          v = '0;
      return v;
   endfunction

   always_comb begin
      w_rd1_next = f_read(ra1);
      w_rd2_next = f_read(ra2);
   end

   always_comb begin
      w_busy_next = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         w_busy_next[i] = (r_busy[i] && !(w_wr_eff && (wa == ADDR_W'(i))))
                          || (w_rsv_eff && (rsv_addr == ADDR_W'(i)));
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         localparam logic [DATA_W-1:0] RST_VAL = DATA_W'(gi * INIT_STEP);
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_mem[gi] <= RST_VAL;
            else if (w_wr_eff && (wa == ADDR_W'(gi)))
               r_mem[gi] <= wd;
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_busy <= '0;
      else
         r_busy <= w_busy_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_busy1 <= 1'b0;
         r_busy2 <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= rd_en;
         if (rd_en) begin
            r_rd1   <= w_rd1_next;
            r_rd2   <= w_rd2_next;
            r_busy1 <= w_busy_next[ra1];
            r_busy2 <= w_busy_next[ra2];
         end
      end
   end

   assign rd1_data = r_rd1;
   assign rd2_data = r_rd2;
   assign busy1    = r_busy1;
   assign busy2    = r_busy2;
   assign rd_valid = r_valid;
   assign busy_vec = r_busy;

endmodule

// File: tb/tb_reg_bank_param.sv
// Scoreboard bench for reg_bank_param: a default instance (bypass, zero r0)
// and an 8-bit instance without bypass or zero register.
module tb_reg_bank_param;

   typedef struct {
      string       tag;
      logic [31:0] d1;
      logic [31:0] d2;
      logic        b1;
      logic        b2;
      logic [7:0]  bv;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // instance A: defaults
   logic        a_rd_en = 0, a_we = 0, a_rsv_en = 0;
   logic [2:0]  a_ra1 = 0, a_ra2 = 0, a_wa = 0, a_rsv_addr = 0;
   logic [31:0] a_wd = 0;
   logic [31:0] a_rd1, a_rd2;
   logic        a_b1, a_b2, a_valid;
   logic [7:0]  a_bvec;

   // instance B: 8-bit, step 40, no bypass, no zero register
   logic        b_rd_en = 0, b_we = 0, b_rsv_en = 0;
   logic [2:0]  b_ra1 = 0, b_ra2 = 0, b_wa = 0, b_rsv_addr = 0;
   logic [7:0]  b_wd = 0;
   logic [7:0]  b_rd1, b_rd2;
   logic        b_b1, b_b2, b_valid;
   logic [7:0]  b_bvec;

   reg_bank_param dut_a (
      .clk(clk), .rst(rst), .rd_en(a_rd_en), .ra1(a_ra1), .ra2(a_ra2),
      .rd1_data(a_rd1), .rd2_data(a_rd2), .busy1(a_b1), .busy2(a_b2),
      .rd_valid(a_valid), .we(a_we), .wa(a_wa), .wd(a_wd),
      .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .busy_vec(a_bvec)
   );

   reg_bank_param #(.DATA_W(8), .ADDR_W(3), .INIT_STEP(40), .ZERO_R0(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .rd_en(b_rd_en), .ra1(b_ra1), .ra2(b_ra2),
      .rd1_data(b_rd1), .rd2_data(b_rd2), .busy1(b_b1), .busy2(b_b2),
      .rd_valid(b_valid), .we(b_we), .wa(b_wa), .wd(b_wd),
      .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .busy_vec(b_bvec)
   );

   exp_t qa[$];
   exp_t qb[$];
   int   n_total = 0;
   int   n_bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_entry(input exp_t e, input logic [31:0] d1, input logic [31:0] d2,
                              input logic b1, input logic b2, input logic [7:0] bv);
      check({e.tag, ".rd1"},  d1, e.d1);
      check({e.tag, ".rd2"},  d2, e.d2);
      check({e.tag, ".busy1"}, {31'd0, b1}, {31'd0, e.b1});
      check({e.tag, ".busy2"}, {31'd0, b2}, {31'd0, e.b2});
      check({e.tag, ".bvec"}, {24'd0, bv}, {24'd0, e.bv});
   endtask

   always @(negedge clk) begin
      if (a_valid) begin
         if (qa.size() == 0) check("A.unexpected_valid", 32'd1, 32'd0);
         else check_entry(qa.pop_front(), a_rd1, a_rd2, a_b1, a_b2, a_bvec);
      end
   end

   always @(negedge clk) begin
      if (b_valid) begin
         if (qb.size() == 0) check("B.unexpected_valid", 32'd1, 32'd0);
         else check_entry(qb.pop_front(), {24'd0, b_rd1}, {24'd0, b_rd2}, b_b1, b_b2, b_bvec);
      end
   end

   // One clock of stimulus on A; expected read response queued when rd_en=1.
   task automatic a_cyc(input string tag, input logic we, input logic [2:0] wa, input logic [31:0] wd,
                        input logic rsv, input logic [2:0] ra, input logic rd, input logic [2:0] r1,
                        input logic [2:0] r2, input logic [31:0] e1, input logic [31:0] e2,
                        input logic eb1, input logic eb2, input logic [7:0] ebv);
      exp_t e;
      a_we = we; a_wa = wa; a_wd = wd; a_rsv_en = rsv; a_rsv_addr = ra;
      a_rd_en = rd; a_ra1 = r1; a_ra2 = r2;
      if (rd) begin
         e.tag = tag; e.d1 = e1; e.d2 = e2; e.b1 = eb1; e.b2 = eb2; e.bv = ebv;
         qa.push_back(e);
      end
      @(posedge clk); #1;
      a_we = 0; a_rsv_en = 0; a_rd_en = 0;
   endtask

   task automatic b_cyc(input string tag, input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic rsv, input logic [2:0] ra, input logic rd, input logic [2:0] r1,
                        input logic [2:0] r2, input logic [31:0] e1, input logic [31:0] e2,
                        input logic eb1, input logic eb2, input logic [7:0] ebv);
      exp_t e;
      b_we = we; b_wa = wa; b_wd = wd; b_rsv_en = rsv; b_rsv_addr = ra;
      b_rd_en = rd; b_ra1 = r1; b_ra2 = r2;
      if (rd) begin
         e.tag = tag; e.d1 = e1; e.d2 = e2; e.b1 = eb1; e.b2 = eb2; e.bv = ebv;
         qb.push_back(e);
      end
      @(posedge clk); #1;
      b_we = 0; b_rsv_en = 0; b_rd_en = 0;
   endtask

   initial begin
      #12;
      check("rst.rd1",   a_rd1, 32'd0);
      check("rst.valid", {31'd0, a_valid}, 32'd0);
      check("rst.bvec",  {24'd0, a_bvec}, 32'd0);
      @(posedge clk); #1;
      rst = 0;

      //     tag   we wa  wd            rsv ra rd r1 r2 e1            e2     b1 b2 bv
      a_cyc("A1",  0, 0, 32'h0,         0, 0, 1, 3, 7, 32'd30,       32'd70, 0, 0, 8'h00);
      a_cyc("A2",  1, 5, 32'hDEADBEEF,  0, 0, 1, 5, 4, 32'hDEADBEEF, 32'd40, 0, 0, 8'h00);
      a_cyc("A3",  0, 0, 32'h0,         0, 0, 1, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 8'h00);
      a_cyc("A4",  1, 0, 32'h1234,      1, 0, 1, 0, 1, 32'd0,        32'd10, 0, 0, 8'h00);
      a_cyc("A5",  0, 0, 32'h0,         0, 0, 1, 0, 6, 32'd0,        32'd60, 0, 0, 8'h00);
      a_cyc("A6",  0, 0, 32'h0,         1, 2, 1, 2, 3, 32'd20,       32'd30, 1, 0, 8'h04);
      a_cyc("A7",  0, 0, 32'h0,         0, 0, 1, 2, 2, 32'd20,       32'd20, 1, 1, 8'h04);
      a_cyc("A8",  1, 2, 32'h22,        0, 0, 1, 2, 7, 32'h22,       32'd70, 0, 0, 8'h00);
      a_cyc("A9",  1, 4, 32'h44,        1, 4, 1, 4, 2, 32'h44,       32'h22, 1, 0, 8'h10);
      a_cyc("A10", 1, 4, 32'h55,        0, 0, 0, 0, 0, 32'd0,        32'd0,  0, 0, 8'h00);
      a_cyc("A11", 0, 0, 32'h0,         0, 0, 1, 4, 7, 32'h55,       32'd70, 0, 0, 8'h00);
      a_cyc("A12", 1, 6, 32'hFF,        1, 1, 1, 6, 1, 32'hFF,       32'd10, 0, 1, 8'h02);
      a_cyc("A13", 0, 0, 32'h0,         0, 0, 1, 6, 1, 32'hFF,       32'd10, 0, 1, 8'h02);

      // asynchronous reset in the low phase, after the monitor has sampled A13
      @(negedge clk); #2;
      rst = 1;
      #1;
      check("arst.rd1",   a_rd1, 32'd0);
      check("arst.rd2",   a_rd2, 32'd0);
      check("arst.busy2", {31'd0, a_b2}, 32'd0);
      check("arst.valid", {31'd0, a_valid}, 32'd0);
      check("arst.bvec",  {24'd0, a_bvec}, 32'd0);
      @(posedge clk); #1;
      rst = 0;
      a_cyc("A14", 0, 0, 32'h0,         0, 0, 1, 6, 1, 32'd60,       32'd10, 0, 0, 8'h00);

      b_cyc("B1",  0, 0, 8'h00,         0, 0, 1, 7, 0, 32'd24,       32'd0,   0, 0, 8'h00);
      b_cyc("B2",  1, 5, 8'hAB,         0, 0, 1, 5, 3, 32'd200,      32'd120, 0, 0, 8'h00);
      b_cyc("B3",  0, 0, 8'h00,         0, 0, 1, 5, 6, 32'hAB,       32'd240, 0, 0, 8'h00);
      b_cyc("B4",  1, 0, 8'h12,         1, 0, 1, 0, 4, 32'd0,        32'd160, 1, 0, 8'h01);
      b_cyc("B5",  0, 0, 8'h00,         0, 0, 1, 0, 4, 32'h12,       32'd160, 1, 0, 8'h01);

      repeat (3) @(posedge clk);
      #1;
      check("A.queue_drained", qa.size(), 32'd0);
      check("B.queue_drained", qb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
